minicalc_cmd_arbiter: RTL and testbench

Command scheduler in front of the MiniCalc2 core. It merges two requesters into one command port with a valid/ready handshake: the four debounced push-buttons and ASCII command bytes from the UART receiver. The sources are arbitrated round-robin. UART-sourced commands are acknowledged through the shared UART transmitter. It sits between the debouncers/UART RX and the calculator core's Reset/Stop/Up/Down controls.

---
 rtl/minicalc_cmd_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_minicalc_cmd_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/minicalc_cmd_arbiter.sv
// Round-robin command scheduler that merges debounced push-buttons and UART
// command bytes onto the MiniCalc2 core command port, with an optional UART acknowledge.
module minicalc_cmd_arbiter #(
  parameter logic [7:0] ACK_CHAR   = 8'h4B,
  parameter bit         ENABLE_ACK = 1'b1,
  parameter int         CNT_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       BtnLevel,
  input  logic             RxValid,
  input  logic [7:0]       RxData,
  input  logic             CmdReady,
  output logic             CmdValid,
  output logic [1:0]       CmdCode,
  output logic             CmdSrc,
  input  logic             TxBusy,
  output logic             TxStart,
  output logic [7:0]       TxByte,
  output logic [CNT_W-1:0] DropCount,
  output logic [CNT_W-1:0] ErrCount,
  output logic             Busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t           state_r;
  logic [3:0]       btn_prev_r;
  logic [3:0]       pending_r;
  logic             hold_valid_r;
  logic [1:0]       hold_code_r;
  logic             last_src_r;
  logic             cmd_valid_r;
  logic [1:0]       cmd_code_r;
  logic             cmd_src_r;
  logic             tx_start_r;
  logic             busy_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;

  logic [3:0]       btn_edge_s;
  logic [3:0]       clr_mask_s;
  logic             accept_s;
  logic [2:0]       rx_dec_s;
  logic             rx_cmd_ok_s;
  logic             rx_err_s;
  logic             hold_free_s;
  logic             rx_load_s;
  logic             rx_drop_s;
  logic [1:0]       btn_code_s;
  logic             btn_req_s;
  logic             uart_req_s;
  logic             sel_src_s;
  logic [1:0]       sel_code_s;

  // Returns {valid, code} for an ASCII command byte; either letter case is accepted.
  function automatic logic [2:0] decode_cmd(input logic [7:0] b);
    logic [2:0] r;
    case (b)
      8'h72, 8'h52: r = 3'b100;
      8'h73, 8'h53: r = 3'b101;
      8'h75, 8'h55: r = 3'b110;
      8'h64, 8'h44: r = 3'b111;
      default:      r = 3'b000;
    endcase
    return r;
  endfunction

  assign btn_edge_s  = BtnLevel & ~btn_prev_r;
  assign accept_s    = (state_r == ST_OFFER) && cmd_valid_r && CmdReady;
  assign rx_dec_s    = decode_cmd(RxData);
  assign rx_cmd_ok_s = RxValid & rx_dec_s[2];
  assign rx_err_s    = RxValid & ~rx_dec_s[2];
  // The holding register may be refilled in the same cycle its UART command is accepted.
  assign hold_free_s = ~hold_valid_r | (accept_s & cmd_src_r);
  assign rx_load_s   = rx_cmd_ok_s & hold_free_s;
  assign rx_drop_s   = rx_cmd_ok_s & ~hold_free_s;
  assign btn_req_s   = |pending_r;
  assign uart_req_s  = hold_valid_r;

  // Pending bit released by an accepted button command.
  always_comb begin
    clr_mask_s = 4'b0000;
    if (accept_s && !cmd_src_r) begin
      clr_mask_s[cmd_code_r] = 1'b1;
    end else begin
      clr_mask_s = 4'b0000;
    end
  end

  // Fixed priority among pending buttons: Reset > Stop > Up > Down.
  always_comb begin
    btn_code_s = 2'd0;
    if (pending_r[0]) begin
      btn_code_s = 2'd0;
    end else if (pending_r[1]) begin
      btn_code_s = 2'd1;
    end else if (pending_r[2]) begin
      btn_code_s = 2'd2;
    end else begin
      btn_code_s = 2'd3;
    end
  end

  // Round-robin source pick: on a tie the source that did not win last time goes.
  always_comb begin
    sel_src_s = 1'b0;
    if (btn_req_s && uart_req_s) begin
      sel_src_s = ~last_src_r;
    end else if (uart_req_s) begin
      sel_src_s = 1'b1;
    end else begin
      sel_src_s = 1'b0;
    end
    sel_code_s = sel_src_s ? hold_code_r : btn_code_s;
  end

  // Button edge capture; a new edge wins over a same-cycle clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_prev_r <= 4'b1111;
      pending_r  <= 4'b0000;
    end else begin
      btn_prev_r <= BtnLevel;
      pending_r  <= (pending_r & ~clr_mask_s) | btn_edge_s;
    end
  end

  // UART command holding register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_valid_r <= 1'b0;
      hold_code_r  <= 2'd0;
    end else if (rx_load_s) begin
      hold_valid_r <= 1'b1;
      hold_code_r  <= rx_dec_s[1:0];
    end else if (accept_s && cmd_src_r) begin
      hold_valid_r <= 1'b0;
    end
  end

  // Saturating drop and error counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      drop_cnt_r <= '0;
      err_cnt_r  <= '0;
    end else begin
      if (rx_drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
      if (rx_err_s && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
    end
  end

  // Scheduler FSM with registered command, acknowledge and busy outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      cmd_valid_r <= 1'b0;
      cmd_code_r  <= 2'd0;
      cmd_src_r   <= 1'b0;
      tx_start_r  <= 1'b0;
      busy_r      <= 1'b0;
      last_src_r  <= 1'b1;
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (btn_req_s || uart_req_s) begin
            cmd_code_r  <= sel_code_s;
            cmd_src_r   <= sel_src_s;
            cmd_valid_r <= 1'b1;
            state_r     <= ST_OFFER;
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_OFFER: begin
          if (accept_s) begin
            cmd_valid_r <= 1'b0;
            last_src_r  <= cmd_src_r;
            if (cmd_src_r && ENABLE_ACK) begin
              state_r <= ST_ACK;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_OFFER;
            busy_r  <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!TxBusy) begin
            tx_start_r <= 1'b1;
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
          end else begin
            state_r <= ST_ACK;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign CmdValid  = cmd_valid_r;
  assign CmdCode   = cmd_code_r;
  assign CmdSrc    = cmd_src_r;
  assign TxStart   = tx_start_r;
  assign TxByte    = ACK_CHAR;
  assign DropCount = drop_cnt_r;
  assign ErrCount  = err_cnt_r;
  assign Busy      = busy_r;

endmodule

// File: tb/tb_minicalc_cmd_arbiter.sv
// Table-driven self-checking bench for minicalc_cmd_arbiter with a few
// hand-written sequences for reset-in-flight and counter saturation.
module tb_minicalc_cmd_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] BtnLevel;
  logic       RxValid;
  logic [7:0] RxData;
  logic       CmdReady;
  logic       CmdValid;
  logic [1:0] CmdCode;
  logic       CmdSrc;
  logic       TxBusy;
  logic       TxStart;
  logic [7:0] TxByte;
  logic [7:0] DropCount;
  logic [7:0] ErrCount;
  logic       Busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  btn;
    logic        rxv;
    logic [7:0]  rxd;
    logic        rdy;
    logic        txb;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];

  minicalc_cmd_arbiter dut (
    .Clk(Clk), .Reset(Reset), .BtnLevel(BtnLevel), .RxValid(RxValid),
    .RxData(RxData), .CmdReady(CmdReady), .CmdValid(CmdValid),
    .CmdCode(CmdCode), .CmdSrc(CmdSrc), .TxBusy(TxBusy), .TxStart(TxStart),
    .TxByte(TxByte), .DropCount(DropCount), .ErrCount(ErrCount), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Row: inputs applied before an edge, outputs expected just after it.
  // Expected packing: {CmdValid, CmdCode, CmdSrc, TxStart, Busy, DropCount, ErrCount}.
  task automatic add(input logic [3:0] btn, input logic rxv, input logic [7:0] rxd,
                     input logic rdy, input logic txb,
                     input logic v, input logic [1:0] c, input logic s, input logic t,
                     input logic b, input logic [7:0] d, input logic [7:0] e);
    vec_t x;
    x.btn = btn; x.rxv = rxv; x.rxd = rxd; x.rdy = rdy; x.txb = txb;
    x.exp = {v, c, s, t, b, d, e};
    vecs.push_back(x);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic seen;
    Reset = 1'b1; BtnLevel = 4'b0100; RxValid = 1'b0; RxData = 8'h00;
    CmdReady = 1'b1; TxBusy = 1'b0;

    // Button held through reset release must not produce a command.
    for (int i = 0; i < 10; i++) add(4'b0100, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // Stop button and UART 'd' together: button wins the first tie, then UART with ACK.
    add(4'b0110, 1'b1, 8'h64, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    // Up button edge: offered two cycles after the input change, for exactly one cycle.
    add(4'b0010, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    // Up offered with CmdReady low; 'u' held, 'r' dropped, 'A' counted as an error.
    add(4'b0010, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    add(4'b0110, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    add(4'b0110, 1'b1, 8'h75, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    add(4'b0110, 1'b1, 8'h72, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0);
    add(4'b0110, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
    // UART 'S' accepted while the transmitter is busy: ACK waits, then one TxStart.
    add(4'b0110, 1'b1, 8'h53, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1);
    for (int i = 0; i < 4; i++) add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    add(4'b0110, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);

    // Reset values while reset is held.
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", {19'd0, CmdValid, CmdCode, CmdSrc, TxStart, Busy, DropCount, ErrCount},
          32'd0);
    check("tx_byte", {24'd0, TxByte}, 32'h0000004B);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      BtnLevel = vecs[i].btn;
      RxValid  = vecs[i].rxv;
      RxData   = vecs[i].rxd;
      CmdReady = vecs[i].rdy;
      TxBusy   = vecs[i].txb;
      step();
      check($sformatf("vec%0d", i),
            {10'd0, CmdValid, CmdCode, CmdSrc, TxStart, Busy, DropCount, ErrCount},
            {10'd0, vecs[i].exp});
    end

    // Reset arriving mid-OFFER with all four buttons pending.
    RxValid = 1'b0; CmdReady = 1'b0; TxBusy = 1'b0;
    BtnLevel = 4'b0000;
    step();
    BtnLevel = 4'b1111;
    step();
    step();
    check("offer_before_reset", {29'd0, CmdValid, CmdCode}, {29'd0, 1'b1, 2'd0});
    #3;
    Reset = 1'b1;
    #1;
    check("async_reset_outputs", {19'd0, CmdValid, CmdCode, CmdSrc, TxStart, Busy, DropCount, ErrCount},
          32'd0);
    step();
    Reset = 1'b0;
    CmdReady = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (CmdValid || TxStart || Busy) seen = 1'b1;
    end
    check("no_cmd_after_reset", {31'd0, seen}, 32'd0);

    // Error counter saturation.
    RxValid = 1'b1;
    RxData  = 8'h41;
    for (int i = 0; i < 254; i++) step();
    check("err_count_254", {24'd0, ErrCount}, 32'h000000FE);
    for (int i = 0; i < 46; i++) step();
    check("err_count_sat", {24'd0, ErrCount}, 32'h000000FF);
    check("drop_count_zero", {23'd0, CmdValid, DropCount}, 32'd0);
    RxValid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
